bsnn_spike_classifier: RTL



---
 rtl/bsnn_pkg.sv | 18 +
 rtl/bsnn_group_popcount.sv | 19 +
 rtl/bsnn_spike_classifier.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bsnn_pkg.sv
// Shared types and helpers for the BSNN spike classifier.
//   bsnn_cls_state_e : result FSM state (IDLE, SCAN, HOLD)
//   bsnn_cnt_width   : width of a per-class counter that can hold window*group
//                      spikes without overflow
package bsnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } bsnn_cls_state_e;

  function automatic int unsigned bsnn_cnt_width(input int unsigned window,
                                                 input int unsigned group);
    return $clog2(window * group + 1);
  endfunction

endpackage

// File: rtl/bsnn_group_popcount.sv
// Combinational popcount of one class's neuron slice.
//   slice : GROUP-bit spike slice of one class
//   count : number of ones in slice, zero-extended to CNT_W bits
module bsnn_group_popcount #(
  parameter int unsigned GROUP = 32,
  parameter int unsigned CNT_W = 9
) (
  input  logic [GROUP-1:0] slice,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < GROUP; i++) begin
      count = count + CNT_W'(slice[i]);
    end
  end

endmodule

// File: rtl/bsnn_spike_classifier.sv
// Per-class spike accumulation over a window of frames, followed by a
// sequential argmax of the finished window presented on a valid/ready port.
//   clk, rst      : clock, asynchronous active-low reset
//   valid         : spike_vector carries a frame this cycle
//   spike_vector  : output-layer spikes, class c owns [c*GROUP +: GROUP]
//   flush         : abandon the current window (counters and frame_cnt clear)
//   out_ready     : consumer accepts the result
//   out_valid     : result available
//   out_class     : winning class index (lowest index on ties)
//   out_score     : winning class spike count
//   overrun       : sticky, a completed window was dropped
//   frame_cnt     : frames accepted in the current window
// The window time (WINDOW cycles minimum) must be at least N_CLASSES+1 cycles
// for a consumer holding out_ready high to never see an overrun.
module bsnn_spike_classifier
  import bsnn_pkg::*;
#(
  parameter int unsigned N_NEURONS = 256,
  parameter int unsigned N_CLASSES = 8,
  parameter int unsigned WINDOW    = 16,
  localparam int unsigned GROUP = N_NEURONS / N_CLASSES,
  localparam int unsigned CNT_W = bsnn_cnt_width(WINDOW, GROUP),
  localparam int unsigned CLS_W = $clog2(N_CLASSES),
  localparam int unsigned FRM_W = $clog2(WINDOW + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [N_NEURONS-1:0] spike_vector,
  input  logic                 flush,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [CLS_W-1:0]     out_class,
  output logic [CNT_W-1:0]     out_score,
  output logic                 overrun,
  output logic [FRM_W-1:0]     frame_cnt
);

  localparam logic [FRM_W-1:0] WIN_LAST = FRM_W'(WINDOW - 1);
  localparam logic [CLS_W-1:0] IDX_LAST = CLS_W'(N_CLASSES - 1);

  logic [CNT_W-1:0] pop   [N_CLASSES];
  logic [CNT_W-1:0] sum   [N_CLASSES];
  logic [CNT_W-1:0] acc_q [N_CLASSES];
  logic [CNT_W-1:0] snap_q[N_CLASSES];

  bsnn_cls_state_e  state_q;
  logic [CLS_W-1:0] idx_q;
  logic [CLS_W-1:0] best_cls_q;
  logic [CNT_W-1:0] best_score_q;
  logic [CLS_W-1:0] scan_cls;
  logic [CNT_W-1:0] scan_score;

  logic accept;
  logic complete;
  logic load;

  for (genvar c = 0; c < N_CLASSES; c++) begin : g_pop
    bsnn_group_popcount #(
      .GROUP (GROUP),
      .CNT_W (CNT_W)
    ) u_pop (
      .slice (spike_vector[c*GROUP +: GROUP]),
      .count (pop[c])
    );
  end

  always_comb begin
    for (int c = 0; c < N_CLASSES; c++) begin
      sum[c] = acc_q[c] + pop[c];
    end
  end

  // A frame arriving with flush is discarded along with the window.
  assign accept   = valid && !flush;
  assign complete = accept && (frame_cnt == WIN_LAST);
  // A finished window is only kept when the result side is free to take it,
  // including a handshake that completes on the same edge.
  assign load     = complete && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));

  // Accumulator bank and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      for (int c = 0; c < N_CLASSES; c++) acc_q[c] <= '0;
    end else if (flush || complete) begin
      frame_cnt <= '0;
      for (int c = 0; c < N_CLASSES; c++) acc_q[c] <= '0;
    end else if (accept) begin
      frame_cnt <= frame_cnt + FRM_W'(1);
      for (int c = 0; c < N_CLASSES; c++) acc_q[c] <= sum[c];
    end
  end

  // Strictly-greater compare keeps the lowest index on ties.
  always_comb begin
    scan_cls   = best_cls_q;
    scan_score = best_score_q;
    if (snap_q[idx_q] > best_score_q) begin
      scan_cls   = idx_q;
      scan_score = snap_q[idx_q];
    end
  end

  // Result FSM, snapshot bank and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      best_cls_q   <= '0;
      best_score_q <= '0;
      out_valid    <= 1'b0;
      out_class    <= '0;
      out_score    <= '0;
      overrun      <= 1'b0;
      for (int c = 0; c < N_CLASSES; c++) snap_q[c] <= '0;
    end else begin
      if (complete && !load) overrun <= 1'b1;
      if (load) begin
        for (int c = 0; c < N_CLASSES; c++) snap_q[c] <= sum[c];
      end
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q      <= SCAN;
            idx_q        <= '0;
            best_cls_q   <= '0;
            best_score_q <= '0;
          end
        end
        SCAN: begin
          best_cls_q   <= scan_cls;
          best_score_q <= scan_score;
          idx_q        <= idx_q + CLS_W'(1);
          if (idx_q == IDX_LAST) begin
            state_q   <= HOLD;
            out_valid <= 1'b1;
            out_class <= scan_cls;
            out_score <= scan_score;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (load) begin
              state_q      <= SCAN;
              idx_q        <= '0;
              best_cls_q   <= '0;
              best_score_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
